// File: rtl/ubutterfly_pipe_if.sv
// ubutterfly_pipe_if
//   Input and output handshake bundle for the butterfly pipeline.
//
//   Valid/ready rule for both channels: a transfer happens on a rising
//   clock edge where valid and ready are both high. A producer holds
//   valid and its payload steady until that transfer.
//
//   Signals
//     in_valid, in_ready  input channel handshake
//     s                   0 = DIT, 1 = DIF, travels with the sample
//     a, b                signed data, DW bits
//     w                   signed real twiddle, WW bits
//     out_valid, out_ready output channel handshake
//     out_a, out_b        signed results, OW bits
//
//   Modports
//     master  the upstream/downstream side (drives the inputs, takes the results)
//     slave   the butterfly itself
interface ubutterfly_pipe_if #(
  parameter int DW = 8,
  parameter int WW = 8,
  parameter int OW = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 s;
  logic signed [DW-1:0] a;
  logic signed [DW-1:0] b;
  logic signed [WW-1:0] w;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_a;
  logic signed [OW-1:0] out_b;

  modport master (
    output in_valid, s, a, b, w, out_ready,
    input  in_ready, out_valid, out_a, out_b
  );

  modport slave (
    input  in_valid, s, a, b, w, out_ready,
    output in_ready, out_valid, out_a, out_b
  );
endinterface

// File: rtl/ubutterfly_pipe.sv
// ubutterfly_pipe
//   Three-stage unified radix-2 butterfly (DIT or DIF per sample).
//     DIT: out_a = a + w*b, out_b = a - w*b
//     DIF: out_a = a + b,   out_b = w*(a - b)
//   Results are computed at full precision (DW+WW+1 bits), optionally
//   rounded (half-up) and right-shifted by SHIFT, then saturated (SAT=1)
//   or wrapped (SAT=0) to OW bits.
//
//   Ports
//     clk       rising-edge clock
//     rst       synchronous active-high reset; discards in-flight samples
//     bus       ubutterfly_pipe_if slave: in/out valid-ready channels
//     sat_flag  sticky: set when any result saturated or wrapped
//     clr_flag  clears sat_flag (a simultaneous new overflow wins)
//
//   The whole pipe advances together: adv = !out_valid | out_ready, and
//   in_ready is adv. When adv is low every stage holds, so the output is
//   stable under backpressure and nothing is lost or duplicated.
module ubutterfly_pipe #(
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int OW    = 16,
  parameter int SHIFT = 0,
  parameter int SAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  ubutterfly_pipe_if.slave    bus,
  output logic                sat_flag,
  input  logic                clr_flag
);
  localparam int FW = DW + WW + 1;                 // full-precision width
  localparam int RW = FW + 1;                      // room for the rounding add
  localparam int CW = ((RW > OW) ? RW : OW) + 1;   // compare width for range check

  localparam logic signed [RW-1:0] HALF =
    (SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;
  localparam logic signed [CW-1:0] ONE  = CW'(1);
  localparam logic signed [CW-1:0] MAXV = (ONE <<< (OW - 1)) - ONE;
  localparam logic signed [CW-1:0] MINV = -(ONE <<< (OW - 1));

  logic adv;

  // stage 1: raw capture
  logic                 s1_valid;
  logic                 s1_s;
  logic signed [DW-1:0] s1_a;
  logic signed [DW-1:0] s1_b;
  logic signed [WW-1:0] s1_w;

  // stage 2: DIT keeps x=a, y=w*b; DIF keeps x=a+b, y=a-b and w
  logic                 s2_valid;
  logic                 s2_s;
  logic signed [FW-1:0] s2_x;
  logic signed [FW-1:0] s2_y;
  logic signed [WW-1:0] s2_w;

  // stage 3: output registers
  logic                 s3_valid;
  logic signed [OW-1:0] s3_a;
  logic signed [OW-1:0] s3_b;

  logic signed [FW-1:0] s2_x_d;
  logic signed [FW-1:0] s2_y_d;
  logic signed [FW-1:0] ra;
  logic signed [FW-1:0] rb;
  logic [OW:0]          pa;
  logic [OW:0]          pb;

  assign adv           = !s3_valid | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = s3_valid;
  assign bus.out_a     = s3_a;
  assign bus.out_b     = s3_b;

  // Round, shift and range-limit one full-precision result.
  // Returns {overflow, value}.
  function automatic logic [OW:0] post(input logic signed [FW-1:0] r);
    logic signed [RW-1:0] t;
    logic signed [CW-1:0] c;
    logic [OW-1:0]        v;
    logic                 ovf;
    t   = (RW'(r) + HALF) >>> SHIFT;
    c   = CW'(t);
    ovf = (c > MAXV) || (c < MINV);
    v   = c[OW-1:0];
    if (ovf && (SAT != 0)) begin
      v = (c > MAXV) ? MAXV[OW-1:0] : MINV[OW-1:0];
    end
    return {ovf, v};
  endfunction

  always_comb begin
    s2_x_d = '0;
    s2_y_d = '0;
    if (!s1_s) begin
      s2_x_d = FW'(s1_a);
      s2_y_d = FW'(s1_w) * FW'(s1_b);
    end else begin
      s2_x_d = FW'(s1_a) + FW'(s1_b);
      s2_y_d = FW'(s1_a) - FW'(s1_b);
    end
  end

  // w*(a-b) is bounded by 2^(DW+WW-1), so the low FW bits of the product are exact.
  always_comb begin
    ra = '0;
    rb = '0;
    if (!s2_s) begin
      ra = s2_x + s2_y;
      rb = s2_x - s2_y;
    end else begin
      ra = s2_x;
      rb = FW'(s2_w) * s2_y;
    end
  end

  assign pa = post(ra);
  assign pb = post(rb);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s3_a     <= '0;
      s3_b     <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_s <= bus.s;
          s1_a <= bus.a;
          s1_b <= bus.b;
          s1_w <= bus.w;
        end
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_s <= s1_s;
          s2_x <= s2_x_d;
          s2_y <= s2_y_d;
          s2_w <= s1_w;
        end
        s3_valid <= s2_valid;
        if (s2_valid) begin
          s3_a <= pa[OW-1:0];
          s3_b <= pb[OW-1:0];
        end
      end
      // a new overflow loading into stage 3 beats a clear in the same cycle
      if (adv && s2_valid && (pa[OW] || pb[OW])) begin
        sat_flag <= 1'b1;
      end else if (clr_flag) begin
        sat_flag <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ubutterfly_pipe.sv
// tb_ubutterfly_pipe
//   Four butterflies share one stimulus stream: defaults, OW=8 saturating,
//   OW=8 wrapping, and SHIFT=1. A monitor compares every result of every
//   instance against an arithmetic reference model, tracks the sticky flag,
//   output stability under backpressure, in_ready and reset behaviour.
module tb_ubutterfly_pipe;
  localparam int N = 4;
  localparam int SH_C [N]  = '{0, 0, 0, 1};
  localparam int OW_C [N]  = '{16, 8, 8, 16};
  localparam int SAT_C [N] = '{1, 1, 0, 1};

  typedef struct {
    longint ea;
    longint eb;
    bit     ovf;
    int     acc;
    bit     lat;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared stimulus
  logic              in_valid = 1'b0;
  logic              s_i = 1'b0;
  logic signed [7:0] a_i = '0;
  logic signed [7:0] b_i = '0;
  logic signed [7:0] w_i = '0;
  logic              out_ready = 1'b1;
  logic              clr_flag = 1'b0;
  bit                mark_lat = 1'b0;

  ubutterfly_pipe_if #(.DW(8), .WW(8), .OW(16)) bus0 ();
  ubutterfly_pipe_if #(.DW(8), .WW(8), .OW(8))  bus1 ();
  ubutterfly_pipe_if #(.DW(8), .WW(8), .OW(8))  bus2 ();
  ubutterfly_pipe_if #(.DW(8), .WW(8), .OW(16)) bus3 ();

  logic sf [N];

  assign bus0.in_valid = in_valid; assign bus0.s = s_i; assign bus0.a = a_i;
  assign bus0.b = b_i; assign bus0.w = w_i; assign bus0.out_ready = out_ready;
  assign bus1.in_valid = in_valid; assign bus1.s = s_i; assign bus1.a = a_i;
  assign bus1.b = b_i; assign bus1.w = w_i; assign bus1.out_ready = out_ready;
  assign bus2.in_valid = in_valid; assign bus2.s = s_i; assign bus2.a = a_i;
  assign bus2.b = b_i; assign bus2.w = w_i; assign bus2.out_ready = out_ready;
  assign bus3.in_valid = in_valid; assign bus3.s = s_i; assign bus3.a = a_i;
  assign bus3.b = b_i; assign bus3.w = w_i; assign bus3.out_ready = out_ready;

  ubutterfly_pipe #(.DW(8), .WW(8), .OW(16), .SHIFT(0), .SAT(1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .sat_flag(sf[0]), .clr_flag(clr_flag));
  ubutterfly_pipe #(.DW(8), .WW(8), .OW(8), .SHIFT(0), .SAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .sat_flag(sf[1]), .clr_flag(clr_flag));
  ubutterfly_pipe #(.DW(8), .WW(8), .OW(8), .SHIFT(0), .SAT(0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .sat_flag(sf[2]), .clr_flag(clr_flag));
  ubutterfly_pipe #(.DW(8), .WW(8), .OW(16), .SHIFT(1), .SAT(1)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .sat_flag(sf[3]), .clr_flag(clr_flag));

  logic   ov [N];
  logic   ir [N];
  longint oa [N];
  longint ob [N];

  assign ov[0] = bus0.out_valid; assign ir[0] = bus0.in_ready;
  assign ov[1] = bus1.out_valid; assign ir[1] = bus1.in_ready;
  assign ov[2] = bus2.out_valid; assign ir[2] = bus2.in_ready;
  assign ov[3] = bus3.out_valid; assign ir[3] = bus3.in_ready;
  assign oa[0] = longint'(bus0.out_a); assign ob[0] = longint'(bus0.out_b);
  assign oa[1] = longint'(bus1.out_a); assign ob[1] = longint'(bus1.out_b);
  assign oa[2] = longint'(bus2.out_a); assign ob[2] = longint'(bus2.out_b);
  assign oa[3] = longint'(bus3.out_a); assign ob[3] = longint'(bus3.out_b);

  // scoreboard state
  exp_t   exp_q [N][$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  bit     flag_exp [N];
  bit     prev_ov [N];
  longint hold_a [N];
  longint hold_b [N];
  bit     prev_or = 1'b1;
  bit     prev_clr = 1'b0;
  bit     prev_rst = 1'b1;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // reference: round half up, floor shift, then clamp or wrap to ow bits
  function automatic void post_ref(input longint r, input int sh, input int ow, input int sat,
                                   output longint v, output bit ovf);
    longint div, t, lo, hi, m;
    t = r;
    if (sh > 0) begin
      div = longint'(1) << sh;
      t   = r + div / 2;
      t   = (t - (((t % div) + div) % div)) / div;
    end
    lo  = -(longint'(1) << (ow - 1));
    hi  = (longint'(1) << (ow - 1)) - 1;
    m   = longint'(1) << ow;
    ovf = (t > hi) || (t < lo);
    v   = t;
    if (ovf) begin
      if (sat != 0) v = (t > hi) ? hi : lo;
      else          v = ((((t - lo) % m) + m) % m) + lo;
    end
  endfunction

  function automatic exp_t model(input int d, input bit s, input longint a, input longint b,
                                 input longint w);
    exp_t   e;
    longint ra, rb;
    bit     o1, o2;
    if (!s) begin
      ra = a + w * b;
      rb = a - w * b;
    end else begin
      ra = a + b;
      rb = w * (a - b);
    end
    post_ref(ra, SH_C[d], OW_C[d], SAT_C[d], e.ea, o1);
    post_ref(rb, SH_C[d], OW_C[d], SAT_C[d], e.eb, o2);
    e.ovf = o1 | o2;
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // monitor: all signals sampled mid-cycle; "prev_*" hold what the last edge saw
  always @(negedge clk) begin
    exp_t e;
    bit   load;
    cyc++;
    for (int d = 0; d < N; d++) begin
      if (prev_rst) begin
        exp_q[d].delete();
        flag_exp[d] = 1'b0;
        chk($sformatf("rst_out_valid[%0d]", d), longint'(ov[d]), 0);
        chk($sformatf("rst_out_a[%0d]", d), oa[d], 0);
        chk($sformatf("rst_out_b[%0d]", d), ob[d], 0);
        chk($sformatf("rst_sat_flag[%0d]", d), longint'(sf[d]), 0);
      end else begin
        load = ov[d] && (!prev_ov[d] || prev_or);
        if (prev_ov[d] && !prev_or) begin
          chk($sformatf("stall_valid[%0d]", d), longint'(ov[d]), 1);
          chk($sformatf("stall_out_a[%0d]", d), oa[d], hold_a[d]);
          chk($sformatf("stall_out_b[%0d]", d), ob[d], hold_b[d]);
        end
        if (load) begin
          if (exp_q[d].size() == 0) begin
            chk($sformatf("unexpected_out[%0d]", d), 1, 0);
          end else begin
            e = exp_q[d].pop_front();
            chk($sformatf("out_a[%0d]", d), oa[d], e.ea);
            chk($sformatf("out_b[%0d]", d), ob[d], e.eb);
            if (e.lat) chk($sformatf("latency[%0d]", d), longint'(cyc - e.acc), 3);
            if (e.ovf) flag_exp[d] = 1'b1;
            else if (prev_clr) flag_exp[d] = 1'b0;
          end
        end else if (prev_clr) begin
          flag_exp[d] = 1'b0;
        end
        chk($sformatf("sat_flag[%0d]", d), longint'(sf[d]), longint'(flag_exp[d]));
      end
      chk($sformatf("in_ready[%0d]", d), longint'(ir[d]), longint'(!ov[d] || out_ready));
      prev_ov[d] = ov[d];
      hold_a[d]  = oa[d];
      hold_b[d]  = ob[d];
    end
    // the next edge accepts this sample
    if (!rst && in_valid && ir[0]) begin
      for (int d = 0; d < N; d++) begin
        e = model(d, s_i, longint'(a_i), longint'(b_i), longint'(w_i));
        e.acc = cyc;
        e.lat = mark_lat;
        exp_q[d].push_back(e);
      end
    end
    prev_or  = out_ready;
    prev_clr = clr_flag;
    prev_rst = rst;
  end

  // driver: called just after a rising edge, returns just after the accepting edge
  task automatic send(input bit sv, input int av, input int bv, input int wv, input bit lat);
    in_valid = 1'b1;
    s_i      = sv;
    a_i      = av[7:0];
    b_i      = bv[7:0];
    w_i      = wv[7:0];
    mark_lat = lat;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ir[0]) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        mark_lat = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_timeout", 1, 0);
    in_valid = 1'b0;
    mark_lat = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    // reset
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("in_ready_after_reset", longint'(ir[0]), 1);

    // single DIT, latency
    send(1'b0, 10, 2, 3, 1'b1);
    idle(5);

    // back-to-back mixed modes
    send(1'b1, -5, 4, -2, 1'b1);
    send(1'b0, -7, -3, 2, 1'b1);
    send(1'b1, -7, -3, 2, 1'b1);
    idle(5);

    // overflow, then clear the sticky flag
    send(1'b0, 127, 127, 127, 1'b1);
    idle(5);
    clr_flag = 1'b1;
    idle(1);
    clr_flag = 1'b0;
    idle(2);

    // rounding cases
    send(1'b0, 10, 2, 3, 1'b1);
    send(1'b1, 5, 0, 1, 1'b1);
    send(1'b1, -128, 127, -128, 1'b1);
    idle(5);

    // backpressure mid-stream
    fork
      begin
        send(1'b0, 1, 2, 3, 1'b0);
        send(1'b1, 4, -5, 6, 1'b0);
        send(1'b0, -7, 8, -9, 1'b0);
        send(1'b1, 10, 11, -12, 1'b0);
      end
      begin
        idle(3);
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
      end
    join
    idle(6);

    // reset with samples in flight
    send(1'b0, 1, 2, 3, 1'b0);
    send(1'b1, 4, 5, 6, 1'b0);
    send(1'b0, -8, 7, -9, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(5);
    chk("post_rst_out_a", oa[0], 0);
    chk("post_rst_out_b", ob[0], 0);
    send(1'b0, 10, 2, 3, 1'b1);
    idle(5);

    // random traffic with random backpressure and clears
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      acc = in_valid && ir[0];
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        s_i      = 1'($urandom_range(0, 1));
        a_i      = 8'($urandom);
        b_i      = 8'($urandom);
        w_i      = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      clr_flag  = ($urandom_range(0, 15) == 0);
    end
    in_valid  = 1'b0;
    clr_flag  = 1'b0;
    out_ready = 1'b1;

    // drain
    for (int k = 0; k < 50; k++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
          exp_q[2].size() == 0 && exp_q[3].size() == 0) break;
      idle(1);
    end
    idle(2);
    for (int d = 0; d < N; d++) begin
      chk($sformatf("drain[%0d]", d), longint'(exp_q[d].size()), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ubutterfly_pipe.md
Name: ubutterfly_pipe

Overview:
- Pipelined, parametrised unified radix-2 butterfly for the FFT datapath.
- Selects DIT or DIF per sample via a mode bit carried with the data.
- Full-precision internal arithmetic, optional rounding right-shift, and saturation or wrap to the output width.
- Valid/ready handshake on input and output so it can sit between FFT stage buffers with backpressure.

Parameters:
- DW, 8: width of signed data inputs a and b.
- WW, 8: width of signed twiddle input w.
- OW, 16: width of signed outputs out_a and out_b.
- SHIFT, 0: arithmetic right shift applied before output, with round-half-up when SHIFT>0; legal range 0..DW+WW.
- SAT, 1: 1 = saturate to OW on overflow; 0 = wrap (keep the low OW bits).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  block accepts a sample this cycle.
- s  in  1  mode: 0 = DIT, 1 = DIF; sampled with the data.
- a  in  DW  signed data input a.
- b  in  DW  signed data input b.
- w  in  WW  signed twiddle (real).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_a  out  OW  signed result a.
- out_b  out  OW  signed result b.
- sat_flag  out  1  sticky: set when any output saturated (SAT=1) or wrapped (SAT=0).
- clr_flag  in  1  clears sat_flag.

Behaviour:
- Arithmetic (full-precision width FW = DW+WW+1, all signed):
  - DIT: out_a = a + w*b; out_b = a - w*b.
  - DIF: out_a = a + b; out_b = w*(a - b).
- Post-processing on each FW result r:
  - If SHIFT>0: r' = (r + 2^(SHIFT-1)) >>> SHIFT; otherwise r' = r.
  - If r' is outside [-2^(OW-1), 2^(OW-1)-1]: SAT=1 clamps to that bound; SAT=0 keeps the low OW bits.
  - Either case sets sat_flag on the cycle the result loads into stage 3.
- Pipeline, three register stages:
  - S1: capture a, b, w, s.
  - S2: DIT forms w*b and keeps a; DIF forms a+b and a-b.
  - S3: final add/sub/multiply, shift, saturate; drives out_a/out_b.
  - Each stage has a valid bit; s travels with its sample.
- Latency: exactly 3 cycles from an accepted input (in_valid & in_ready) to out_valid, when no stall occurs.
- Handshake:
  - Global advance: adv = !out_valid | out_ready; in_ready = adv.
  - When adv=0, all stages, including valid bits, hold their values.
  - out_a/out_b stay stable while out_valid=1 and out_ready=0.
  - Throughput is one sample per cycle when out_ready is held high.
  - Bubbles (in_valid=0 while adv=1) propagate as invalid stages.
- Reset:
  - Clears all valid bits, out_a, out_b and sat_flag to 0; in_ready reads 1 in the cycle after reset.
  - Reset mid-stream discards every in-flight sample; no output appears for them.
- sat_flag:
  - If clr_flag and a new overflow occur in the same cycle, the set wins.
  - sat_flag never self-clears.
- Mode mixing: consecutive samples may alternate s; each result follows its own s.
- No combinational path from in_valid to out_valid. The only combinational path from out_ready is to in_ready.

Test Plan:
- Defaults; DIT a=10,b=2,w=3 accepted at cycle T -> out_valid at T+3 with out_a=16, out_b=4; sat_flag=0.
- Back-to-back: DIF a=-5,b=4,w=-2, then DIT a=-7,b=-3,w=2, then DIF a=-7,b=-3,w=2 -> three consecutive out_valid cycles giving (-1,18), (-13,-1), (-10,-8).
- Backpressure: stream 4 samples with out_ready low for 3 cycles mid-stream -> in_ready low while stalled; outputs held stable; no sample lost or duplicated; order preserved.
- OW=8, SAT=1; DIT a=127,b=127,w=127 -> out_a=127, out_b=-128, sat_flag=1. Pulse clr_flag -> sat_flag=0. Same test with SAT=0 -> out_a=-128 (16256 low byte is 0x80), out_b=126 (low byte of -16002 is 0x7E), sat_flag=1.
- SHIFT=1: DIT a=10,b=2,w=3 -> (8,2). DIF a=5,b=0,w=1 -> out_a=3, out_b=3 (round-half-up of 2.5).
- Assert rst with 3 samples in flight -> no out_valid afterward; out_a=out_b=0. The next accepted sample emerges after exactly 3 cycles with the correct value.
